byte_unstrip_n: RTL and testbench

BYTE_UNSTRIP_N -- requirements
Module: byte_unstrip_n

---
 rtl/byte_strip_pkg.sv | 14 +
 rtl/unstrip_lane_fifo.sv | 59 +++++
 rtl/byte_unstrip_n.sv | 112 +++++++++++
 tb/tb_byte_unstrip_n.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/byte_strip_pkg.sv
// Shared definitions for the byte unstriping datapath: FSM state type and
// default geometry.
package byte_strip_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    localparam int unsigned DefLanes = 4;
    localparam int unsigned DefWidth = 32;
    localparam int unsigned DefDepth = 4;

endpackage

// File: rtl/unstrip_lane_fifo.sv
// Per-lane FIFO with combinational head output. Pointers wrap modulo DEPTH and
// occupancy is tracked in a separate counter one bit wider than the pointers.
module unstrip_lane_fifo
    import byte_strip_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned DEPTH = DefDepth
) (
    input  logic             clk_f,
    input  logic             reset_L,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign dout    = mem[rd_q];
    // A push into a full FIFO is dropped even if a pop frees a slot on the same edge.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk_f) begin
        if (!reset_L) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage is deliberately left without reset.
    always_ff @(posedge clk_f) begin
        if (do_push) mem[wr_q] <= din;
    end

endmodule

// File: rtl/byte_unstrip_n.sv
// Reassembles a word stream striped round-robin across LANES lanes, buffering
// each lane to absorb skew and stalling in order when a lane runs dry.
module byte_unstrip_n
    import byte_strip_pkg::*;
#(
    parameter int unsigned LANES = DefLanes,
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned DEPTH = DefDepth
) (
    input  logic                   clk_f,
    input  logic                   reset_L,
    input  logic [LANES-1:0]       valid_in,
    input  logic [LANES*WIDTH-1:0] lane_in,
    output logic [LANES-1:0]       lane_ready,
    input  logic                   realign,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       data_out,
    output logic                   valid_out,
    output logic [LANES-1:0]       overflow,
    output logic                   aligned
);
    localparam int unsigned PtrW = $clog2(LANES);

    state_e           state_q, state_d;
    logic [PtrW-1:0]  ptr_q, ptr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [LANES-1:0] ovf_q;
    logic [LANES-1:0] full, empty, pop;
    logic [WIDTH-1:0] head [LANES];

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        unstrip_lane_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk_f   (clk_f),
            .reset_L (reset_L),
            .flush   (realign),
            .push    (valid_in[k]),
            .pop     (pop[k]),
            .din     (lane_in[k*WIDTH +: WIDTH]),
            .dout    (head[k]),
            .full    (full[k]),
            .empty   (empty[k])
        );
    end

    assign lane_ready = ~full;
    assign data_out   = data_q;
    assign valid_out  = valid_q;
    assign overflow   = ovf_q;
    assign aligned    = (state_q == StRun);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        valid_d = valid_q;
        pop     = '0;
        if (realign) begin
            state_d = StIdle;
            ptr_d   = '0;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    valid_d = 1'b0;
                    ptr_d   = '0;
                    // Lock once every lane holds a word; lane 0 is emitted on the same edge.
                    if (empty == '0) begin
                        state_d = StRun;
                        pop[0]  = 1'b1;
                        data_d  = head[0];
                        valid_d = 1'b1;
                        ptr_d   = PtrW'(1);
                    end
                end
                StRun: begin
                    if (!valid_q || out_ready) begin
                        if (!empty[ptr_q]) begin
                            pop[ptr_q] = 1'b1;
                            data_d     = head[ptr_q];
                            valid_d    = 1'b1;
                            ptr_d      = ptr_q + PtrW'(1);
                        end else begin
                            valid_d = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_f) begin
        if (!reset_L) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_q | (valid_in & full);
        end
    end

endmodule

// File: tb/tb_byte_unstrip_n.sv
// Bench for byte_unstrip_n: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a queue-based reference model.
module tb_byte_unstrip_n;
    localparam int unsigned LANES = 4;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;

    logic                   clk_f;
    logic                   reset_L;
    logic [LANES-1:0]       valid_in;
    logic [LANES*WIDTH-1:0] lane_in;
    logic [LANES-1:0]       lane_ready;
    logic                   realign;
    logic                   out_ready;
    logic [WIDTH-1:0]       data_out;
    logic                   valid_out;
    logic [LANES-1:0]       overflow;
    logic                   aligned;

    byte_unstrip_n #(
        .LANES (LANES),
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk_f      (clk_f),
        .reset_L    (reset_L),
        .valid_in   (valid_in),
        .lane_in    (lane_in),
        .lane_ready (lane_ready),
        .realign    (realign),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .overflow   (overflow),
        .aligned    (aligned)
    );

    initial clk_f = 1'b0;
    always #5 clk_f = ~clk_f;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: one queue per lane, stream position, and output register.
    logic [WIDTH-1:0] mq [LANES][$];
    bit               m_live = 0;
    bit               m_run;
    int               m_ptr;
    logic [WIDTH-1:0] m_data;
    bit               m_valid;
    logic [LANES-1:0] m_ovf;

    always @(posedge clk_f) begin
        if (!reset_L) begin
            for (int k = 0; k < LANES; k++) mq[k].delete();
            m_run = 0; m_ptr = 0; m_data = '0; m_valid = 0; m_ovf = '0; m_live = 1;
        end else if (m_live) begin
            bit full_pre [LANES];
            bit all_have;
            for (int k = 0; k < LANES; k++) begin
                full_pre[k] = (mq[k].size() == DEPTH);
                if (valid_in[k] && full_pre[k]) m_ovf[k] = 1'b1;
            end
            if (realign) begin
                for (int k = 0; k < LANES; k++) mq[k].delete();
                m_run = 0; m_ptr = 0; m_valid = 0;
            end else begin
                all_have = 1;
                for (int k = 0; k < LANES; k++) if (mq[k].size() == 0) all_have = 0;
                if (!m_run) begin
                    if (all_have) begin
                        m_run = 1; m_data = mq[0].pop_front(); m_valid = 1; m_ptr = 1;
                    end
                end else if (!m_valid || out_ready) begin
                    if (mq[m_ptr].size() != 0) begin
                        m_data = mq[m_ptr].pop_front(); m_valid = 1;
                        m_ptr = (m_ptr + 1) % LANES;
                    end else begin
                        m_valid = 0;
                    end
                end
                for (int k = 0; k < LANES; k++)
                    if (valid_in[k] && !full_pre[k]) mq[k].push_back(lane_in[k*WIDTH +: WIDTH]);
            end
        end
    end

    always @(negedge clk_f) begin
        if (m_live) begin
            logic [LANES-1:0] m_ready;
            for (int k = 0; k < LANES; k++) m_ready[k] = (mq[k].size() < DEPTH);
            chk("m_valid_out", {31'b0, valid_out}, {31'b0, m_valid});
            chk("m_data_out", data_out, m_data);
            chk("m_aligned", {31'b0, aligned}, {31'b0, m_run});
            chk("m_overflow", {28'b0, overflow}, {28'b0, m_ovf});
            chk("m_lane_ready", {28'b0, lane_ready}, {28'b0, m_ready});
        end
    end

    task automatic tick();
        @(posedge clk_f);
        #1;
    endtask

    task automatic set_lane(input int k, input logic [WIDTH-1:0] v);
        lane_in[k*WIDTH +: WIDTH] = v;
    endtask

    task automatic push_round(input logic [LANES-1:0] mask, input logic [WIDTH-1:0] base);
        valid_in = mask;
        for (int k = 0; k < LANES; k++) set_lane(k, base + WIDTH'(k));
    endtask

    // Run n cycles with no new input, capturing every accepted output word.
    task automatic collect(input int n, output logic [WIDTH-1:0] got [$]);
        got.delete();
        valid_in = '0;
        for (int t = 0; t < n; t++) begin
            tick();
            if (valid_out) got.push_back(data_out);
        end
    endtask

    task automatic chk_seq(input string name, input logic [WIDTH-1:0] got [$],
                           input logic [WIDTH-1:0] exp [$]);
        chk({name, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) chk(name, got[i], exp[i]);
    endtask

    logic [WIDTH-1:0] got [$];
    logic [WIDTH-1:0] exp [$];

    initial begin
        reset_L = 1'b0; realign = 1'b0; out_ready = 1'b1;
        valid_in = '0; lane_in = '0;
        #1;
        tick(); tick();
        reset_L = 1'b1;
        chk("rst_valid", {31'b0, valid_out}, 32'd0);
        chk("rst_aligned", {31'b0, aligned}, 32'd0);
        chk("rst_overflow", {28'b0, overflow}, 32'd0);
        chk("rst_data", data_out, 32'd0);
        chk("rst_ready", {28'b0, lane_ready}, 32'hF);

        // Aligned round, out_ready=1
        push_round(4'hF, 32'hA0);
        tick();
        valid_in = '0;
        chk("basic_pre", {31'b0, valid_out}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("basic_word", data_out, 32'hA0 + i);
            chk("basic_valid", {31'b0, valid_out}, 32'd1);
        end
        tick();
        chk("basic_drain", {31'b0, valid_out}, 32'd0);

        // Skew: lane 2 three cycles late
        realign = 1'b1; tick(); realign = 1'b0;
        push_round(4'b1011, 32'hB0);
        tick();
        valid_in = '0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("skew_aligned", {31'b0, aligned}, 32'd0);
            chk("skew_valid", {31'b0, valid_out}, 32'd0);
        end
        push_round(4'b0100, 32'hB0);
        tick();
        valid_in = '0;
        chk("skew_aligned_w", {31'b0, aligned}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("skew_word", data_out, 32'hB0 + i);
            chk("skew_aligned_r", {31'b0, aligned}, 32'd1);
        end
        tick();

        // Backpressure for 5 cycles mid-stream
        push_round(4'hF, 32'hC00);
        tick();
        push_round(4'hF, 32'hC10);
        tick();
        valid_in = '0;
        chk("bp_w0", data_out, 32'hC00);
        tick();
        chk("bp_w1", data_out, 32'hC01);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold", data_out, 32'hC01);
            chk("bp_hold_v", {31'b0, valid_out}, 32'd1);
        end
        out_ready = 1'b1;
        exp = '{32'hC02, 32'hC03, 32'hC10, 32'hC11, 32'hC12, 32'hC13};
        collect(8, got);
        chk_seq("bp_seq", got, exp);

        // Overflow on lane 1 while stalled on lane 0
        for (int i = 0; i < 5; i++) begin
            valid_in = 4'b0010;
            set_lane(1, 32'hD0 + i);
            tick();
        end
        valid_in = '0;
        chk("ovf_flag", {28'b0, overflow}, 32'h2);
        chk("ovf_ready", {28'b0, lane_ready}, 32'hD);
        got.delete();
        exp.delete();
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < LANES; k++)
                exp.push_back(k == 1 ? 32'hD0 + r : 32'hE00 + 32'(r * 16 + k));
        end
        for (int t = 0; t < 24; t++) begin
            if (t < 4) push_round(4'b1101, 32'hE00 + 32'(t * 16));
            else valid_in = '0;
            tick();
            if (valid_out) got.push_back(data_out);
        end
        chk_seq("ovf_seq", got, exp);
        chk("ovf_sticky", {28'b0, overflow}, 32'h2);

        // Lane 3 starved after the first round
        push_round(4'hF, 32'h100);
        tick();
        push_round(4'b0111, 32'h110);
        tick();
        got.delete();
        got.push_back(data_out);
        begin
            logic [WIDTH-1:0] rest [$];
            collect(10, rest);
            foreach (rest[i]) got.push_back(rest[i]);
        end
        exp = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h110, 32'h111, 32'h112};
        chk_seq("stall_seq", got, exp);
        chk("stall_valid", {31'b0, valid_out}, 32'd0);
        chk("stall_aligned", {31'b0, aligned}, 32'd1);
        valid_in = 4'b1000;
        set_lane(3, 32'h113);
        tick();
        valid_in = '0;
        chk("stall_still", {31'b0, valid_out}, 32'd0);
        tick();
        chk("stall_resume", data_out, 32'h113);
        chk("stall_resume_v", {31'b0, valid_out}, 32'd1);
        tick();

        // Realign mid-stream
        push_round(4'hF, 32'h200);
        tick();
        push_round(4'hF, 32'h210);
        tick();
        valid_in = '0;
        tick();
        realign = 1'b1; tick(); realign = 1'b0;
        chk("ra_valid", {31'b0, valid_out}, 32'd0);
        chk("ra_aligned", {31'b0, aligned}, 32'd0);
        chk("ra_overflow", {28'b0, overflow}, 32'h2);
        chk("ra_ready", {28'b0, lane_ready}, 32'hF);
        push_round(4'hF, 32'h300);
        tick();
        exp = '{32'h300, 32'h301, 32'h302, 32'h303};
        collect(8, got);
        chk_seq("ra_seq", got, exp);

        // Reset mid-stream
        push_round(4'hF, 32'h400);
        tick();
        push_round(4'hF, 32'h410);
        tick();
        valid_in = '0;
        tick();
        reset_L = 1'b0; tick(); reset_L = 1'b1;
        chk("mr_valid", {31'b0, valid_out}, 32'd0);
        chk("mr_aligned", {31'b0, aligned}, 32'd0);
        chk("mr_overflow", {28'b0, overflow}, 32'd0);
        chk("mr_data", data_out, 32'd0);
        chk("mr_ready", {28'b0, lane_ready}, 32'hF);
        push_round(4'hF, 32'h500);
        tick();
        exp = '{32'h500, 32'h501, 32'h502, 32'h503};
        collect(8, got);
        chk_seq("mr_seq", got, exp);

        // Randomized traffic against the model
        for (int t = 0; t < 3000; t++) begin
            reset_L   = ($urandom_range(0, 299) != 0);
            realign   = ($urandom_range(0, 59) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            valid_in  = realign ? '0 : LANES'($urandom & $urandom_range(0, 15));
            for (int k = 0; k < LANES; k++) set_lane(k, $urandom);
            tick();
        end
        reset_L = 1'b1; realign = 1'b0; valid_in = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
